// File: rtl/find_keypoints_ms.sv
// Multi-scale DoG keypoint finder: scans interior pixels, tests each middle level for a strict
// 3x3x3 extremum above a contrast threshold and writes {level, y, x} words to a keypoint BRAM.
module find_keypoints_ms #(
  parameter int          BIT_DEPTH    = 8,
  parameter int          WIDTH        = 4,
  parameter int          HEIGHT       = 4,
  parameter int          NUM_LEVELS   = 3,
  parameter int unsigned THRESHOLD    = 0,
  parameter int          READ_LATENCY = 2,
  parameter int          KEY_DEPTH    = WIDTH * HEIGHT,
  localparam int         AW           = $clog2(WIDTH * HEIGHT),
  localparam int         XW           = $clog2(WIDTH),
  localparam int         YW           = $clog2(HEIGHT),
  localparam int         LW           = $clog2(NUM_LEVELS),
  localparam int         KW           = $clog2(KEY_DEPTH + 1),
  localparam int         KAW          = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_in,
  input  logic                            start,
  output logic [AW-1:0]                   dog_read_addr,
  input  logic [NUM_LEVELS*BIT_DEPTH-1:0] dog_data,
  output logic [KAW-1:0]                  key_write_addr,
  output logic                            key_wea,
  output logic [LW+YW+XW-1:0]             keypoint_out,
  output logic [KW-1:0]                   keypoint_count,
  output logic                            overflow,
  output logic                            keypoints_done
);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StEmit, StAdvance, StDone} state_e;

  state_e                        r_state, w_state_next;
  logic [XW-1:0]                 r_x;
  logic [YW-1:0]                 r_y;
  logic [3:0]                    r_idx;
  logic [7:0]                    r_drain;
  logic [LW-1:0]                 r_lvl;
  logic [AW-1:0]                 r_addr;
  logic [KW-1:0]                 r_count;
  logic                          r_ovf;
  logic                          r_pipe_vld [READ_LATENCY];
  logic [3:0]                    r_pipe_idx [READ_LATENCY];
  logic signed [BIT_DEPTH-1:0]   r_center   [NUM_LEVELS-2];
  logic [NUM_LEVELS-3:0]         r_is_max, r_is_min;

  logic signed [BIT_DEPTH-1:0]   w_dog [NUM_LEVELS];
  logic                          w_ret_vld;
  logic [3:0]                    w_ret_idx;
  logic signed [BIT_DEPTH-1:0]   w_center_sel;
  logic signed [BIT_DEPTH:0]     w_ext;
  logic [BIT_DEPTH:0]            w_abs;
  logic                          w_extremum, w_hit, w_room, w_write;
  logic                          w_last;
  logic [XW-1:0]                 w_x_adv;
  logic [YW-1:0]                 w_y_adv;

  // Read index 0 is the center; 1..8 are the neighbors in raster order skipping (0, 0).
  function automatic logic [AW-1:0] addr_of(input int x, input int y, input int k);
    int n, dx, dy;
    n  = (k == 0) ? 4 : ((k <= 4) ? k - 1 : k);
    dx = (n % 3) - 1;
    dy = (n / 3) - 1;
    return AW'((y + dy) * WIDTH + x + dx);
  endfunction

  always_comb begin
    for (int l = 0; l < NUM_LEVELS; l++) w_dog[l] = dog_data[l*BIT_DEPTH +: BIT_DEPTH];
    w_ret_vld = r_pipe_vld[READ_LATENCY-1];
    w_ret_idx = r_pipe_idx[READ_LATENCY-1];
  end

  always_comb begin
    w_center_sel = r_center[0];
    w_extremum   = 1'b0;
    for (int m = 0; m < NUM_LEVELS - 2; m++) begin
      if (int'(r_lvl) == m + 1) begin
        w_center_sel = r_center[m];
        w_extremum   = r_is_max[m] | r_is_min[m];
      end
    end
    // One extra bit so |-2^(BIT_DEPTH-1)| does not wrap.
    w_ext   = (BIT_DEPTH + 1)'(w_center_sel);
    w_abs   = w_ext[BIT_DEPTH] ? unsigned'(-w_ext) : unsigned'(w_ext);
    w_hit   = w_extremum && (32'(w_abs) >= THRESHOLD);
    w_room  = r_count < KW'(KEY_DEPTH);
    w_write = (r_state == StEmit) && w_hit && w_room;
  end

  always_comb begin
    w_last = (r_x == XW'(WIDTH - 2)) && (r_y == YW'(HEIGHT - 2));
    if (r_x == XW'(WIDTH - 2)) begin
      w_x_adv = XW'(1);
      w_y_adv = r_y + YW'(1);
    end else begin
      w_x_adv = r_x + XW'(1);
      w_y_adv = r_y;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (start) w_state_next = StRead;
      StRead:         if (r_idx == 4'd8) w_state_next = StDrain;
      StDrain:        if (r_drain == 8'(READ_LATENCY - 1)) w_state_next = StEmit;
      StEmit:         if (int'(r_lvl) == NUM_LEVELS - 2) w_state_next = StAdvance;
      StAdvance:      w_state_next = w_last ? StDone : StRead;
      default:        w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_x      <= '0;
      r_y      <= '0;
      r_idx    <= '0;
      r_drain  <= '0;
      r_lvl    <= '0;
      r_addr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_is_max <= '0;
      r_is_min <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_idx[i] <= '0;
      end
      for (int m = 0; m < NUM_LEVELS - 2; m++) r_center[m] <= '0;
    end else begin
      r_pipe_vld[0] <= (r_state == StRead);
      r_pipe_idx[0] <= r_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end

      if (w_ret_vld) begin
        for (int m = 0; m < NUM_LEVELS - 2; m++) begin
          if (w_ret_idx == 4'd0) begin
            r_center[m] <= w_dog[m+1];
            r_is_max[m] <= (w_dog[m+1] > w_dog[m]) && (w_dog[m+1] > w_dog[m+2]);
            r_is_min[m] <= (w_dog[m+1] < w_dog[m]) && (w_dog[m+1] < w_dog[m+2]);
          end else begin
            if (!((r_center[m] > w_dog[m]) && (r_center[m] > w_dog[m+1]) &&
                  (r_center[m] > w_dog[m+2]))) r_is_max[m] <= 1'b0;
            if (!((r_center[m] < w_dog[m]) && (r_center[m] < w_dog[m+1]) &&
                  (r_center[m] < w_dog[m+2]))) r_is_min[m] <= 1'b0;
          end
        end
      end

      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_x     <= XW'(1);
            r_y     <= YW'(1);
            r_idx   <= '0;
            r_drain <= '0;
            r_lvl   <= LW'(1);
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_addr  <= addr_of(1, 1, 0);
          end
        end
        StRead: begin
          if (r_idx != 4'd8) begin
            r_idx  <= r_idx + 4'd1;
            r_addr <= addr_of(int'(r_x), int'(r_y), int'(r_idx) + 1);
          end else begin
            r_drain <= '0;
          end
        end
        StDrain: begin
          r_drain <= r_drain + 8'd1;
          r_lvl   <= LW'(1);
        end
        StEmit: begin
          r_lvl <= r_lvl + LW'(1);
          if (w_hit) begin
            if (w_room) r_count <= r_count + KW'(1);
            else        r_ovf   <= 1'b1;
          end
        end
        StAdvance: begin
          if (!w_last) begin
            r_x    <= w_x_adv;
            r_y    <= w_y_adv;
            r_idx  <= '0;
            r_addr <= addr_of(int'(w_x_adv), int'(w_y_adv), 0);
          end
        end
        default: ;
      endcase
    end
  end

  assign dog_read_addr  = r_addr;
  assign key_wea        = w_write;
  assign key_write_addr = w_write ? KAW'(r_count) : '0;
  assign keypoint_out   = w_write ? {r_lvl, r_y, r_x} : '0;
  assign keypoint_count = r_count;
  assign overflow       = r_ovf;
  assign keypoints_done = (r_state == StDone);

endmodule
